// File: rtl/reg_file_mp_pkg.sv
// Shared types and constants for the multi-read-port register file.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
//
// Contents: rf_state_e FSM encoding, default XLEN/NUM_REGS, ZERO_IDX (hardwired x0).
package rf_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_XLEN     = 32;
  localparam int RF_NUM_REGS = 32;

  // Register index that always reads as zero and never accepts writes.
  localparam int ZERO_IDX = 0;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bundles the writeback, decode-read and control signals of reg_file_mp.
// Latency: n/a (wiring only).
// Backpressure: none; ready marks when the array may be read or written.
//
// Ports (master = pipeline side, slave = register file):
//   rf_en, rd, wdata     writeback port
//   rs, rdata            packed read ports, port i = rs[i] / rdata[i]
//   clr_req              request to zero the whole array
//   ready, wr_dropped    array usable / a write was discarded during clear
interface reg_file_mp_if #(
  parameter int XLEN       = 32,
  parameter int NUM_REGS   = 32,
  parameter int NUM_RPORTS = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                             rf_en;
  logic [AW-1:0]                    rd;
  logic [XLEN-1:0]                  wdata;
  logic [NUM_RPORTS-1:0][AW-1:0]    rs;
  logic [NUM_RPORTS-1:0][XLEN-1:0]  rdata;
  logic                             clr_req;
  logic                             ready;
  logic                             wr_dropped;

  modport master (
    output rf_en, rd, wdata, rs, clr_req,
    input  rdata, ready, wr_dropped
  );

  modport slave (
    input  rf_en, rd, wdata, rs, clr_req,
    output rdata, ready, wr_dropped
  );

endinterface

// File: rtl/reg_file_mp_clear_fsm.sv
// Clear engine: sweeps zeros through registers 1..NUM_REGS-1 after reset or clr_req.
// Latency: NUM_REGS-1 cycles per sweep; ready and wr_dropped are registered.
// Backpressure: writes arriving during a sweep are discarded and flagged on wr_dropped.
//
// Ports: clk, rst (async, active-high); clr_req, rf_en, rd in;
//        clr_we, clr_addr (zeroing write to the array), ready, wr_dropped out.
module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_req,
  input  logic                         rf_en,
  input  logic [$clog2(NUM_REGS)-1:0]  rd,
  output logic                         clr_we,
  output logic [$clog2(NUM_REGS)-1:0]  clr_addr,
  output logic                         ready,
  output logic                         wr_dropped
);
  localparam int AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST_IDX  = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] FIRST_IDX = AW'(ZERO_IDX + 1);

  rf_state_e     state;
  logic [AW-1:0] ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RF_CLEAR;
      ptr        <= FIRST_IDX;
      ready      <= 1'b0;
      wr_dropped <= 1'b0;
    end else begin
      // x0 writes are no-ops everywhere, so they never count as dropped.
      wr_dropped <= (state == RF_CLEAR) && rf_en && (rd != AW'(ZERO_IDX));
      case (state)
        RF_IDLE: begin
          if (clr_req) begin
            state <= RF_CLEAR;
            ptr   <= FIRST_IDX;
            ready <= 1'b0;
          end
        end
        RF_CLEAR: begin
          // clr_req is ignored here: a running sweep is never restarted.
          ptr <= ptr + AW'(1);
          if (ptr == LAST_IDX) begin
            state <= RF_IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= RF_CLEAR;
          ptr   <= FIRST_IDX;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state == RF_CLEAR);
  assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file for decode; x0 hardwired to zero, sequential clear engine.
// Latency: reads combinational, writes visible one cycle later (same cycle with RF_BYPASS_EN).
// Backpressure: none; while ready=0 reads return 0 and writes are dropped (wr_dropped).
//
// Ports: clk, rst (async, active-high), bus (reg_file_mp_if.slave).
// Optional feature: define RF_BYPASS_EN to forward the writeback data to matching read
// ports in the write cycle.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int XLEN       = RF_XLEN,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int NUM_RPORTS = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0]                  mem [NUM_REGS];
  logic                             clr_we;
  logic [AW-1:0]                    clr_addr;
  logic                             ready;
  logic                             wr_dropped;
  logic                             wr_en;
  logic [NUM_RPORTS-1:0][XLEN-1:0]  rdata_w;

  rf_clear_fsm #(
    .NUM_REGS (NUM_REGS)
  ) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (bus.clr_req),
    .rf_en      (bus.rf_en),
    .rd         (bus.rd),
    .clr_we     (clr_we),
    .clr_addr   (clr_addr),
    .ready      (ready),
    .wr_dropped (wr_dropped)
  );

  // ready is only high in IDLE, so a writeback and a sweep write never collide.
  assign wr_en = bus.rf_en && ready && (bus.rd != AW'(ZERO_IDX));

  // Storage carries no reset: the sweep is what defines its contents.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[bus.rd] <= bus.wdata;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RPORTS; i++) begin
      rdata_w[i] = '0;
      if (ready && (bus.rs[i] != AW'(ZERO_IDX))) begin
        rdata_w[i] = mem[bus.rs[i]];
`ifdef RF_BYPASS_EN
        if (wr_en && (bus.rd == bus.rs[i])) begin
          rdata_w[i] = bus.wdata;
        end
`endif
      end
    end
  end

  assign bus.rdata      = rdata_w;
  assign bus.ready      = ready;
  assign bus.wr_dropped = wr_dropped;

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: table-driven IDLE read/write vectors plus hand-written
// sequences for reset sweep, write during clear, write+clear and reset mid-clear.
// Expected values are queued as stimulus is driven and compared when sampled.
module tb_reg_file_mp;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk;
  logic rst;

  reg_file_mp_if #(.XLEN(32), .NUM_REGS(32), .NUM_RPORTS(2)) bus ();

  reg_file_mp #(.XLEN(32), .NUM_REGS(32), .NUM_RPORTS(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [4:0]  rs0;
    logic [4:0]  rs1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  sb_t  sb_q[$];
  vec_t vt[10];
  int   n_pass  = 0;
  int   n_total = 0;
  int   ecount  = 0;

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] got);
    sb_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: got %h with no expectation queued", got);
    end else begin
      e = sb_q.pop_front();
      if (got === e.exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", e.name, got, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_ready(input string name);
    while (!bus.ready && ecount < 100) tick();
    sb_push({name, "_ready"}, 32'd1);
    sb_check({31'd0, bus.ready});
    sb_push({name, "_len"}, 32'd31);
    sb_check(32'(ecount));
  endtask

  task automatic idle_inputs();
    bus.rf_en   = 1'b0;
    bus.rd      = '0;
    bus.wdata   = '0;
    bus.clr_req = 1'b0;
    bus.rs[0]   = '0;
    bus.rs[1]   = '0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0};
    vt[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vt[2] = '{1'b1, 5'd0,  32'h00001234, 5'd0,  5'd5,  32'h0, 32'hDEADBEEF};
    vt[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0, 32'h0};
    vt[4] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd5,  5'd7,  32'hDEADBEEF, BYP ? 32'hA5A5A5A5 : 32'h0};
    vt[5] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF};
    vt[6] = '{1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, BYP ? 32'hFFFFFFFF : 32'h0, 32'h0};
    vt[7] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd1,  32'hFFFFFFFF, BYP ? 32'h1 : 32'h0};
    vt[8] = '{1'b1, 5'd5,  32'h12345678, 5'd5,  5'd1,  BYP ? 32'h12345678 : 32'hDEADBEEF, 32'h1};
    vt[9] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31, 32'h12345678, 32'hFFFFFFFF};

    // Reset state and initial sweep.
    idle_inputs();
    rst = 1'b1;
    bus.rs[0] = 5'd5;
    bus.rs[1] = 5'd31;
    tick();
    tick();
    settle();
    sb_push("rst_ready", 32'd0);       sb_check({31'd0, bus.ready});
    sb_push("rst_wr_dropped", 32'd0);  sb_check({31'd0, bus.wr_dropped});
    sb_push("rst_rdata0", 32'd0);      sb_check(bus.rdata[0]);
    sb_push("rst_rdata1", 32'd0);      sb_check(bus.rdata[1]);
    rst = 1'b0;
    ecount = 0;
    wait_ready("reset_sweep");
    for (int r = 0; r < 32; r++) begin
      bus.rs[0] = 5'(r);
      bus.rs[1] = 5'(31 - r);
      settle();
      sb_push("sweep_zero0", 32'd0);   sb_check(bus.rdata[0]);
      sb_push("sweep_zero1", 32'd0);   sb_check(bus.rdata[1]);
    end

    // Table-driven IDLE read/write vectors.
    for (int v = 0; v < 10; v++) begin
      bus.rf_en = vt[v].we;
      bus.rd    = vt[v].rd;
      bus.wdata = vt[v].wd;
      bus.rs[0] = vt[v].rs0;
      bus.rs[1] = vt[v].rs1;
      sb_push($sformatf("vec%0d_rdata0", v), vt[v].e0);
      sb_push($sformatf("vec%0d_rdata1", v), vt[v].e1);
      settle();
      sb_check(bus.rdata[0]);
      sb_check(bus.rdata[1]);
      tick();
      bus.rf_en = 1'b0;
      sb_push($sformatf("vec%0d_wr_dropped", v), 32'd0);
      sb_check({31'd0, bus.wr_dropped});
    end

    // Write during clear: dropped once, clr_req mid-sweep ignored.
    idle_inputs();
    bus.clr_req = 1'b1;
    tick();
    ecount = 0;
    bus.clr_req = 1'b0;
    sb_push("clr_ready_low", 32'd0);  sb_check({31'd0, bus.ready});
    tick();
    bus.rf_en = 1'b1;
    bus.rd    = 5'd3;
    bus.wdata = 32'h55;
    bus.rs[0] = 5'd3;
    settle();
    sb_push("clr_read_gated", 32'd0); sb_check(bus.rdata[0]);
    tick();
    bus.rf_en = 1'b0;
    sb_push("clr_drop_pulse", 32'd1); sb_check({31'd0, bus.wr_dropped});
    tick();
    sb_push("clr_drop_once", 32'd0);  sb_check({31'd0, bus.wr_dropped});
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    wait_ready("clr_sweep");
    bus.rs[0] = 5'd3;
    bus.rs[1] = 5'd5;
    settle();
    sb_push("clr_rs3_zero", 32'd0);   sb_check(bus.rdata[0]);
    sb_push("clr_rs5_zero", 32'd0);   sb_check(bus.rdata[1]);

    // Simultaneous write and clr_req in IDLE.
    bus.rf_en   = 1'b1;
    bus.rd      = 5'd9;
    bus.wdata   = 32'h77;
    bus.clr_req = 1'b1;
    bus.rs[0]   = 5'd9;
    settle();
    sb_push("wclr_same_cycle", BYP ? 32'h77 : 32'h0); sb_check(bus.rdata[0]);
    tick();
    ecount = 0;
    idle_inputs();
    bus.rs[0] = 5'd9;
    sb_push("wclr_ready_low", 32'd0); sb_check({31'd0, bus.ready});
    sb_push("wclr_no_drop", 32'd0);   sb_check({31'd0, bus.wr_dropped});
    wait_ready("wclr_sweep");
    settle();
    sb_push("wclr_rs9_zero", 32'd0);  sb_check(bus.rdata[0]);

    // Reset in the middle of a clr_req sweep.
    bus.rf_en = 1'b1;
    bus.rd    = 5'd12;
    bus.wdata = 32'hCAFEF00D;
    tick();
    idle_inputs();
    bus.rs[0] = 5'd12;
    settle();
    sb_push("mid_pre_rs12", 32'hCAFEF00D); sb_check(bus.rdata[0]);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    settle();
    sb_push("mid_rst_ready", 32'd0);  sb_check({31'd0, bus.ready});
    tick();
    tick();
    rst = 1'b0;
    ecount = 0;
    wait_ready("mid_rst_sweep");
    settle();
    sb_push("mid_rs12_zero", 32'd0);  sb_check(bus.rdata[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
